// File: rtl/fpu_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// fpu_hazard_scoreboard
//
// Hazard scoreboard for the FP side of the pipelined integer/FP CPU. Every FP
// register write in flight is tracked in a shift-register scoreboard that
// mirrors the NSTAGE-deep FP execution pipe (E1..E_NSTAGE). A single iterative
// div/sqrt unit is tracked by a down-counter, and its result is injected into
// the last scoreboard stage on the cycle it writes back.
//
// From the ID-stage operand/destination fields and that scoreboard the block
// derives the FP stall, the E_NSTAGE forward selects and the FP write-back
// enable/destination.
//
// Parameters
//   NSTAGE     FP execution pipe depth, 2..8
//   NREG       FP register count (register numbers are clog2(NREG) bits)
//   DIV_CYCLES div/sqrt issue-to-write-back latency, must be >= NSTAGE
//
// Ports
//   clk         system clock, rising edge
//   clrn        asynchronous active-low reset
//   id_valid    ID holds a real instruction (0 for a bubble)
//   id_fp       ID instruction is FP arithmetic
//   id_divsqrt  ID instruction is div or sqrt (implies id_fp)
//   id_use_fs   instruction reads fs
//   id_use_ft   instruction reads ft
//   id_fs       fs register number
//   id_ft       ft register number
//   id_fd       fd (destination) register number
//   id_cancel   exception cancel; the ID instruction must not enter the pipe
//   stall       combinational; holds PC/IR and gates the FP issue
//   fwd_a       combinational; operand a takes the E_NSTAGE result
//   fwd_b       combinational; operand b takes the E_NSTAGE result
//   wb_we       registered; FP register-file write enable
//   wb_rn       registered; FP register-file write destination
//   div_busy    registered; iterative div/sqrt unit occupied
//   issue       combinational; the ID FP instruction is accepted this cycle
// -----------------------------------------------------------------------------
module fpu_hazard_scoreboard #(
  parameter int  NSTAGE     = 3,
  parameter int  NREG       = 32,
  parameter int  DIV_CYCLES = 12,
  localparam int AW         = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          id_valid,
  input  logic          id_fp,
  input  logic          id_divsqrt,
  input  logic          id_use_fs,
  input  logic          id_use_ft,
  input  logic [AW-1:0] id_fs,
  input  logic [AW-1:0] id_ft,
  input  logic [AW-1:0] id_fd,
  input  logic          id_cancel,
  output logic          stall,
  output logic          fwd_a,
  output logic          fwd_b,
  output logic          wb_we,
  output logic [AW-1:0] wb_rn,
  output logic          div_busy,
  output logic          issue
);

  // Counter wide enough to hold DIV_CYCLES-1.
  localparam int            CW       = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

  // Scoreboard: stage k holds the destination of the op currently in Ek.
  logic [NSTAGE:1] v;
  logic [AW-1:0]   r [1:NSTAGE];

  // Iterative div/sqrt tracking.
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   div_rn;

  // Per-stage operand matches against the ID instruction.
  logic [NSTAGE:1] hit_fs;
  logic [NSTAGE:1] hit_ft;
  logic            raw_stall;
  logic            div_stall;

  // ---------------------------------------------------------------------------
  // Hazard detection, stall, forwarding and issue
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default at the top of the block, so
  // no path can leave one unassigned and infer a latch.
  always_comb begin
    hit_fs    = '0;
    hit_ft    = '0;
    raw_stall = 1'b0;
    div_stall = 1'b0;
    stall     = 1'b0;
    fwd_a     = 1'b0;
    fwd_b     = 1'b0;
    issue     = 1'b0;

    for (int k = 1; k <= NSTAGE; k++) begin
      hit_fs[k] = id_valid & id_use_fs & v[k] & (r[k] == id_fs);
      hit_ft[k] = id_valid & id_use_ft & v[k] & (r[k] == id_ft);
    end

    // A producer in E1..E_NSTAGE-1 has no result yet; only E_NSTAGE forwards.
    raw_stall = (|hit_fs[NSTAGE-1:1]) | (|hit_ft[NSTAGE-1:1]);

    // While the divider runs, no FP op may issue (that keeps its write-back
    // slot in E_NSTAGE free), and nothing may read its pending destination.
    div_stall = div_busy & id_valid &
                (id_fp |
                 (id_use_ft & (id_ft == div_rn)) |
                 (id_use_fs & (id_fs == div_rn)));

    stall = raw_stall | div_stall;

    fwd_a = hit_fs[NSTAGE] & ~stall;
    fwd_b = hit_ft[NSTAGE] & ~stall;

    // Cancel only blocks entry into the pipe; it does not change stall.
    issue = id_valid & id_fp & ~stall & ~id_cancel;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard shift register and div/sqrt counter
  // ---------------------------------------------------------------------------
  // NOTE: the destination fields are cleared on reset along with the valid
  // bits, because wb_rn is read straight out of the last stage and must read 0
  // after reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v        <= '0;
      for (int k = 1; k <= NSTAGE; k++) begin
        r[k] <= '0;
      end
      cnt      <= '0;
      div_rn   <= '0;
      div_busy <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every stage samples the
      // pre-edge value of its neighbour and the shift does not ripple.
      v[1] <= issue & ~id_divsqrt;
      if (issue & ~id_divsqrt) begin
        r[1] <= id_fd;
      end
      for (int k = 2; k <= NSTAGE; k++) begin
        v[k] <= v[k-1];
        r[k] <= r[k-1];
      end

      if (issue & id_divsqrt) begin
        cnt      <= CNT_LOAD;
        div_rn   <= id_fd;
        div_busy <= 1'b1;
      end else if (cnt > CNT_ONE) begin
        cnt <= cnt - CNT_ONE;
      end else if (cnt == CNT_ONE) begin
        // Inject the div result into E_NSTAGE. This later assignment wins
        // over the shift above; the shifted-in entry is always empty here
        // because nothing issued while the divider was busy.
        v[NSTAGE] <= 1'b1;
        r[NSTAGE] <= div_rn;
        cnt       <= '0;
        div_busy  <= 1'b0;
      end
    end
  end

  assign wb_we = v[NSTAGE];
  assign wb_rn = r[NSTAGE];

endmodule

// File: tb/tb_fpu_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_fpu_hazard_scoreboard
//
// Two scoreboards share one ID stream: instance a (3-stage pipe, 32 registers)
// and instance b (5-stage pipe, 64 registers), both with an 8-cycle divider.
// A behavioural model keeps, per instance, a list of in-flight writes tagged
// with their age since issue; every output is derived from those ages each
// cycle and compared on the falling edge. Directed sequences pin the model with
// hand-computed literal expectations; a randomized stream follows.
// -----------------------------------------------------------------------------
module tb_fpu_hazard_scoreboard;

  localparam int DIVC = 8;
  localparam int MAXE = 16;

  logic       clk  = 1'b0;
  logic       clrn = 1'b0;
  logic       id_valid, id_fp, id_divsqrt, id_use_fs, id_use_ft, id_cancel;
  logic [5:0] id_fs, id_ft, id_fd;

  logic       a_stall, a_fwd_a, a_fwd_b, a_wb_we, a_div_busy, a_issue;
  logic [4:0] a_wb_rn;
  logic       b_stall, b_fwd_a, b_fwd_b, b_wb_we, b_div_busy, b_issue;
  logic [5:0] b_wb_rn;

  fpu_hazard_scoreboard #(.NSTAGE(3), .NREG(32), .DIV_CYCLES(DIVC)) u_a (
    .clk(clk), .clrn(clrn),
    .id_valid(id_valid), .id_fp(id_fp), .id_divsqrt(id_divsqrt),
    .id_use_fs(id_use_fs), .id_use_ft(id_use_ft),
    .id_fs(id_fs[4:0]), .id_ft(id_ft[4:0]), .id_fd(id_fd[4:0]),
    .id_cancel(id_cancel),
    .stall(a_stall), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
    .wb_we(a_wb_we), .wb_rn(a_wb_rn), .div_busy(a_div_busy), .issue(a_issue)
  );

  fpu_hazard_scoreboard #(.NSTAGE(5), .NREG(64), .DIV_CYCLES(DIVC)) u_b (
    .clk(clk), .clrn(clrn),
    .id_valid(id_valid), .id_fp(id_fp), .id_divsqrt(id_divsqrt),
    .id_use_fs(id_use_fs), .id_use_ft(id_use_ft),
    .id_fs(id_fs), .id_ft(id_ft), .id_fd(id_fd),
    .id_cancel(id_cancel),
    .stall(b_stall), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b),
    .wb_we(b_wb_we), .wb_rn(b_wb_rn), .div_busy(b_div_busy), .issue(b_issue)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: in-flight writes with their age in cycles since issue.
  // A pipelined op writes back at age NSTAGE, a div at age DIVC; before that a
  // pipelined op blocks readers, a div blocks readers and all FP issue.
  // ---------------------------------------------------------------------------
  int m_rd  [2][MAXE];
  int m_age [2][MAXE];
  bit m_div [2][MAXE];
  bit m_val [2][MAXE];

  function automatic void model_eval(input int i,
                                     output bit st, output bit fa, output bit fb,
                                     output bit iss, output bit we, output bit busy,
                                     output int rn);
    int n, mask, fs, ft, lat, busy_rn;
    bit raw, hfs, hft, dst, vld;
    n = (i == 0) ? 3 : 5;
    mask = (i == 0) ? 31 : 63;
    fs = int'(id_fs) & mask;
    ft = int'(id_ft) & mask;
    vld = (id_valid === 1'b1);
    raw = 0; hfs = 0; hft = 0; we = 0; busy = 0; rn = 0; busy_rn = 0;
    for (int e = 0; e < MAXE; e++) begin
      if (m_val[i][e]) begin
        lat = m_div[i][e] ? DIVC : n;
        if (m_age[i][e] < lat) begin
          if (m_div[i][e]) begin
            busy = 1;
            busy_rn = m_rd[i][e];
          end else if (vld && ((id_use_fs && m_rd[i][e] == fs) ||
                               (id_use_ft && m_rd[i][e] == ft))) begin
            raw = 1;
          end
        end else begin
          we = 1;
          rn = m_rd[i][e];
          if (vld && id_use_fs && m_rd[i][e] == fs) hfs = 1;
          if (vld && id_use_ft && m_rd[i][e] == ft) hft = 1;
        end
      end
    end
    dst = busy && vld && (id_fp || (id_use_ft && ft == busy_rn) ||
                                  (id_use_fs && fs == busy_rn));
    st  = raw || dst;
    fa  = hfs && !st;
    fb  = hft && !st;
    iss = vld && id_fp && !st && !id_cancel;
  endfunction

  always @(posedge clk or negedge clrn) begin : model_update
    bit st, fa, fb, iss, we, busy;
    int rn, mask, lat, slot;
    if (!clrn) begin
      for (int i = 0; i < 2; i++)
        for (int e = 0; e < MAXE; e++) begin
          m_val[i][e] <= 1'b0;
          m_age[i][e] <= 0;
        end
    end else begin
      for (int i = 0; i < 2; i++) begin
        model_eval(i, st, fa, fb, iss, we, busy, rn);
        mask = (i == 0) ? 31 : 63;
        slot = -1;
        for (int e = 0; e < MAXE; e++) begin
          if (m_val[i][e]) begin
            lat = m_div[i][e] ? DIVC : ((i == 0) ? 3 : 5);
            m_age[i][e] <= m_age[i][e] + 1;
            if (m_age[i][e] >= lat) m_val[i][e] <= 1'b0;
          end else if (slot < 0) begin
            slot = e;
          end
        end
        if (iss && slot >= 0) begin
          m_val[i][slot] <= 1'b1;
          m_age[i][slot] <= 1;
          m_rd[i][slot]  <= int'(id_fd) & mask;
          m_div[i][slot] <= id_divsqrt;
        end
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin : compare
    bit st, fa, fb, iss, we, busy;
    int rn;
    model_eval(0, st, fa, fb, iss, we, busy, rn);
    check("a_stall", a_stall, st);
    check("a_fwd_a", a_fwd_a, fa);
    check("a_fwd_b", a_fwd_b, fb);
    check("a_issue", a_issue, iss);
    check("a_wb_we", a_wb_we, we);
    check("a_div_busy", a_div_busy, busy);
    if (we) check("a_wb_rn", a_wb_rn, rn);
    model_eval(1, st, fa, fb, iss, we, busy, rn);
    check("b_stall", b_stall, st);
    check("b_fwd_a", b_fwd_a, fa);
    check("b_fwd_b", b_fwd_b, fb);
    check("b_issue", b_issue, iss);
    check("b_wb_we", b_wb_we, we);
    check("b_div_busy", b_div_busy, busy);
    if (we) check("b_wb_rn", b_wb_rn, rn);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input bit v, input bit fp, input bit dv, input bit ufs,
                       input bit uft, input int fs, input int ft, input int fd,
                       input bit cn);
    id_valid   = v;
    id_fp      = fp;
    id_divsqrt = dv;
    id_use_fs  = ufs;
    id_use_ft  = uft;
    id_fs      = 6'(fs);
    id_ft      = 6'(ft);
    id_fd      = 6'(fd);
    id_cancel  = cn;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic int pick_reg();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 6) return 31;
    if (r == 7) return 63;
    return r & 3;
  endfunction

  initial begin
    int n;
    idle();
    clrn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    settle();
    check("reset_wb_we", a_wb_we, 0);
    check("reset_wb_rn", a_wb_rn, 0);
    check("reset_b_wb_rn", b_wb_rn, 0);
    check("reset_div_busy", a_div_busy, 0);
    check("reset_stall", a_stall, 0);
    tick();
    clrn = 1'b1;
    tick();

    // Reset in the middle of a divide: the pending result is lost.
    drive(1, 1, 1, 1, 1, 1, 2, 7, 0);
    settle();
    check("pre_reset_div_issue", a_issue, 1);
    tick();
    idle();
    tick();
    settle();
    check("pre_reset_div_busy", a_div_busy, 1);
    clrn = 1'b0;
    #1;
    check("midreset_div_busy", a_div_busy, 0);
    check("midreset_wb_we", a_wb_we, 0);
    check("midreset_stall", a_stall, 0);
    tick();
    clrn = 1'b1;
    n = 0;
    repeat (10) begin
      settle();
      if (a_wb_we || b_wb_we) n++;
      tick();
    end
    check("lost_div_no_wb", n, 0);

    // fadd f3: write-back two edges after issue on the 3-stage pipe.
    drive(1, 1, 0, 1, 1, 1, 2, 3, 0);
    settle();
    check("fadd_f3_issue", a_issue, 1);
    tick();
    idle();
    tick();
    settle();
    check("fadd_f3_wb_early", a_wb_we, 0);
    tick();
    settle();
    check("fadd_f3_wb_we", a_wb_we, 1);
    check("fadd_f3_wb_rn", a_wb_rn, 3);
    tick();
    settle();
    check("fadd_f3_wb_once", a_wb_we, 0);

    // RAW: fmul f4 then fadd reading f4.
    drive(1, 1, 0, 1, 1, 1, 2, 4, 0);
    settle();
    check("fmul_f4_issue", a_issue, 1);
    tick();
    drive(1, 1, 0, 1, 1, 4, 1, 6, 0);
    n = 0;
    settle();
    while (a_stall && n < 10) begin
      n++;
      tick();
      settle();
    end
    check("raw_stall_cycles", n, 2);
    check("raw_issue", a_issue, 1);
    check("raw_fwd_a", a_fwd_a, 1);
    check("raw_fwd_b", a_fwd_b, 0);
    tick();

    // Independent fadd right after fmul does not stall.
    drive(1, 1, 0, 1, 1, 1, 2, 10, 0);
    tick();
    drive(1, 1, 0, 1, 1, 11, 12, 13, 0);
    settle();
    check("indep_stall", a_stall, 0);
    check("indep_issue", a_issue, 1);
    tick();
    idle();
    repeat (6) tick();

    // Dual hit: fs=ft=5 with the producer in E3.
    drive(1, 1, 0, 1, 1, 1, 2, 5, 0);
    settle();
    check("dual_prod_issue", a_issue, 1);
    tick();
    idle();
    tick();
    tick();
    drive(1, 1, 0, 1, 1, 5, 5, 14, 0);
    settle();
    check("dual_stall", a_stall, 0);
    check("dual_fwd_a", a_fwd_a, 1);
    check("dual_fwd_b", a_fwd_b, 1);
    tick();
    idle();
    repeat (6) tick();

    // Divide f7: busy for DIVC-1 cycles; integer ops pass, FP ops wait.
    drive(1, 1, 1, 1, 1, 1, 2, 7, 0);
    settle();
    check("div_issue", a_issue, 1);
    tick();
    drive(1, 0, 0, 1, 0, 9, 0, 0, 0);
    settle();
    check("div_int_no_stall", a_stall, 0);
    check("div_busy_first", a_div_busy, 1);
    n = 1;
    tick();
    drive(1, 1, 0, 1, 1, 7, 1, 8, 0);
    settle();
    while (a_div_busy && n < 20) begin
      check("div_hold_stall", a_stall, 1);
      n++;
      tick();
      settle();
    end
    check("div_busy_cycles", n, 7);
    check("div_wb_we", a_wb_we, 1);
    check("div_wb_rn", a_wb_rn, 7);
    check("div_after_stall", a_stall, 0);
    check("div_after_issue", a_issue, 1);
    check("div_after_fwd_a", a_fwd_a, 1);
    tick();
    idle();
    repeat (8) tick();

    // Cancel: fadd f9 never enters the pipe.
    drive(1, 1, 0, 1, 1, 1, 2, 9, 1);
    settle();
    check("cancel_issue", a_issue, 0);
    check("cancel_stall", a_stall, 0);
    tick();
    drive(1, 0, 0, 0, 1, 0, 9, 0, 0);
    settle();
    check("cancel_reader_stall", a_stall, 0);
    tick();
    idle();
    n = 0;
    repeat (6) begin
      settle();
      if (a_wb_we) n++;
      tick();
    end
    check("cancel_no_wb", n, 0);
    repeat (4) tick();

    // 5-stage instance: dependent chain on f63.
    drive(1, 1, 0, 1, 1, 63, 63, 63, 0);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      settle();
      while (!b_issue && n < 20) begin
        n++;
        tick();
        settle();
      end
      check("chain_stall_cycles", n, (k == 0) ? 0 : 4);
      if (k > 0) begin
        check("chain_fwd_a", b_fwd_a, 1);
        check("chain_fwd_b", b_fwd_b, 1);
      end
      tick();
    end
    idle();
    n = 0;
    settle();
    while (!b_wb_we && n < 10) begin
      n++;
      tick();
      settle();
    end
    check("chain_wb_latency", n, 4);
    check("chain_wb_rn", b_wb_rn, 63);
    repeat (10) tick();

    // Randomized stream with one asynchronous reset pulse in the middle.
    for (int c = 0; c < 1500; c++) begin
      bit v, fp, dv;
      v  = ($urandom_range(0, 7) != 0);
      fp = ($urandom_range(0, 3) != 0);
      dv = fp && ($urandom_range(0, 15) == 0);
      drive(v, fp, dv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            pick_reg(), pick_reg(), pick_reg(), ($urandom_range(0, 9) == 0));
      if (c == 700) begin
        #2;
        clrn = 1'b0;
        tick();
        tick();
        clrn = 1'b1;
      end else begin
        tick();
      end
    end
    idle();
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_hazard_scoreboard.md
# fpu_hazard_scoreboard

Parametrised FP hazard scoreboard for the pipelined integer/FP CPU. Tracks every in-flight floating-point register write through an N-stage FP execution pipe and an iterative div/sqrt unit. From the ID-stage operand/destination fields and a registered shift-register scoreboard, it generates the FP stall, the last-stage forward selects and the FP write-back enable. It supersedes fixed three-stage comparator logic and works for any pipe depth and register-file size.

## Interface
- NSTAGE, 3: FP execution pipe depth (E1..E_NSTAGE); legal 2..8
- NREG, 32: FP register count; AW = clog2(NREG)
- DIV_CYCLES, 12: div/sqrt occupancy in cycles from issue to write-back; must be ≥ NSTAGE
- clk  in  1  system clock, rising edge
- clrn  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction (0 for a bubble)
- id_fp  in  1  ID instruction is FP arithmetic (add/sub/mul/div/sqrt)
- id_divsqrt  in  1  ID instruction is div or sqrt (implies id_fp)
- id_use_fs / id_use_ft  in  1 each  instruction reads fs / ft (swc1 asserts id_use_ft only)
- id_fs, id_ft, id_fd  in  AW each  register numbers
- id_cancel  in  1  exception cancel; the ID instruction must not enter the pipe
- stall  out  1  combinational; holds PC/IR and gates fc
- fwd_a, fwd_b  out  1 each  combinational; select the E_NSTAGE result for operand a / b
- wb_we  out  1  registered; FP register-file write enable
- wb_rn  out  AW  registered; FP write destination
- div_busy  out  1  registered; iterative unit occupied
- issue  out  1  combinational; the ID FP instruction is accepted this cycle

## Operation
- Scoreboard: per stage k = 1..NSTAGE, one valid bit v[k] and a destination r[k].
- Advance every cycle, unconditionally: v[k+1]←v[k], r[k+1]←r[k]. Stage 1 loads (issue & ~id_divsqrt, id_fd); otherwise v[1]←0.
- issue = id_valid & id_fp & ~stall & ~id_cancel.
- Div/sqrt:
  - On issue with id_divsqrt: cnt←DIV_CYCLES-1, div_rn←id_fd, div_busy←1.
  - While cnt>1: cnt decrements.
  - When cnt==1: v[NSTAGE]←1, r[NSTAGE]←div_rn on that edge, overriding the shift; cnt←0, div_busy←0.
  - The override never collides with a pipelined op, because no FP op issues while div_busy.
- Hazard match: hit_s[k] = id_valid & id_use_s & v[k] & (r[k]==id_s), for s ∈ {fs, ft}.
- stall is the OR of:
  - any hit_fs[k] or hit_ft[k] with k < NSTAGE (RAW, result not ready)
  - div_busy & id_valid & (id_fp | (id_use_ft & id_ft==div_rn) | (id_use_fs & id_fs==div_rn))
- fwd_a = hit_fs[NSTAGE] & ~stall; fwd_b = hit_ft[NSTAGE] & ~stall.
- wb_we = v[NSTAGE]; wb_rn = r[NSTAGE].
- All register numbers are compared at full AW width, with no zero exclusion (f0 is a real register).
- id_cancel suppresses issue and does not alter stall. In-flight entries are never flushed: older instructions always complete.

## Timing
- Reset (clrn=0, asynchronous): all v[k]=0, r[k]=0, cnt=0, div_rn=0, div_busy=0. Consequently wb_we=0 and wb_rn=0; stall, fwd_a, fwd_b and issue are 0 when id_valid=0.
- Pipelined op issued at edge T: v[1]=1 after T; wb_we=1 exactly after edge T+NSTAGE-1, for one cycle.
- Dependent op: stalls while the producer is in E1..E_NSTAGE-1. It issues with fwd=1 in the cycle the producer is in E_NSTAGE, i.e. NSTAGE-1 stall cycles for back-to-back dependence.
- Div issued at edge T: div_busy=1 over cycles T..T+DIV_CYCLES-2. wb_we=1 with wb_rn=div_rn in the following cycle; total write latency DIV_CYCLES.
- Reset asserted mid-operation: all state clears immediately; the pending div result is lost.
- Simultaneous div completion and a new FP request: the request still stalls that cycle, because div_busy is still 1. It issues the next cycle, with forwarding from E_NSTAGE if dependent.

## Test plan
- Reset with NSTAGE=3: hold clrn=0 mid-stream → wb_we=0, div_busy=0, stall=0; release, then issue fadd f3 → wb_we=1, wb_rn=3 two edges later.
- RAW: fmul f4←…, then fadd reads fs=4 next cycle → stall=1 for 2 cycles, then issue=1 with fwd_a=1; independent fadd after fmul → no stall.
- Dual hit: fs=ft=5 pending in E3 → fwd_a=fwd_b=1, stall=0.
- Div, DIV_CYCLES=8: fdiv f7 → div_busy=1 for 7 cycles; integer op with id_fp=0 does not stall; fadd stalls until div_busy=0; wb_we=1, wb_rn=7 at cycle 8.
- Cancel: id_cancel=1 on fadd f9 → issue=0; no wb_we for f9; a later reader of f9 is not stalled.
- NSTAGE=5, NREG=64: dependent chain on f63 → 4 stall cycles per link; wb_rn=63.
